// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W    : width of the adder slice (4 bits).
//   nsa_state_e : controller states.
//   width_of()  : operand width for a given nibble count.
package nsa_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } nsa_state_e;

  function automatic int unsigned width_of(input int unsigned nibbles);
    return nibbles * NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Purely combinational 4-bit adder slice: sum = a + b + cin.
// Ports:
//   a, b  : 4-bit addends
//   cin   : carry in
//   sum   : 4-bit sum
//   cout  : carry out of bit 3
//   c3    : carry into bit 3 (only present when NSA_FLAGS_EN is defined; used for overflow)
// Configuration macro: NSA_FLAGS_EN
module nibble_add_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
`ifdef NSA_FLAGS_EN
  ,
  output logic                c3
`endif
);

  logic [3:0] lo;  // {carry into bit 3, sum[2:0]}
  logic [1:0] hi;  // {carry out, sum[3]}
  logic       c3_int;

  always_comb begin
    lo     = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    c3_int = lo[3];
    hi     = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3_int};
    sum    = {hi[0], lo[2:0]};
    cout   = hi[1];
  end

`ifdef NSA_FLAGS_EN
  assign c3 = c3_int;
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder/subtractor using a single 4-bit slice, one nibble per cycle,
// LSB nibble first, with the carry rippling through a register between nibbles.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   start_valid/start_ready   : operand handshake (op_a, op_b, cin, sub sampled on accept)
//   res_valid/res_ready       : result handshake (sum, cout, zero, ovf held while waiting)
//   sum, cout                 : result and carry out (no-borrow flag when subtracting)
//   zero, ovf                 : sum==0 and signed overflow
// Configuration macro: NSA_FLAGS_EN -- when undefined, zero and ovf are tied to 0.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [width_of(NIBBLES)-1:0] op_a,
  input  logic [width_of(NIBBLES)-1:0] op_b,
  input  logic                         cin,
  input  logic                         sub,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [width_of(NIBBLES)-1:0] sum,
  output logic                         cout,
  output logic                         zero,
  output logic                         ovf
);

  localparam int unsigned WIDTH = width_of(NIBBLES);
  localparam int unsigned IdxW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  nsa_state_e          state_q;
  logic [IdxW-1:0]     idx_q;
  logic                carry_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q;
  logic                start_ready_q;
  logic                res_valid_q;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic [WIDTH-1:0]    sum_nxt;

  // Operand nibble select and merge of the slice result into the partial sum.
  always_comb begin
    a_nib   = NIBBLE_W'(a_q >> (int'(idx_q) * NIBBLE_W));
    b_nib   = NIBBLE_W'(b_q >> (int'(idx_q) * NIBBLE_W));
    sum_nxt = sum_q;
    sum_nxt[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = slice_sum;
  end

`ifdef NSA_FLAGS_EN
  logic slice_c3;
  logic zero_q;
  logic ovf_q;

  nibble_add_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );
`else
  nibble_add_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
`ifdef NSA_FLAGS_EN
      zero_q        <= 1'b0;
      ovf_q         <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid && start_ready_q) begin
            a_q           <= op_a;
            // Subtract as A + ~B + 1.
            b_q           <= sub ? ~op_b : op_b;
            carry_q       <= sub | cin;
            idx_q         <= '0;
            start_ready_q <= 1'b0;
            state_q       <= StRun;
          end
        end
        StRun: begin
          sum_q   <= sum_nxt;
          carry_q <= slice_cout;
          idx_q   <= idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            cout_q      <= slice_cout;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
`ifdef NSA_FLAGS_EN
            zero_q      <= (sum_nxt == '0);
            ovf_q       <= slice_c3 ^ slice_cout;
`endif
          end
        end
        StDone: begin
          if (res_ready) begin
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: begin
          res_valid_q   <= 1'b0;
          start_ready_q <= 1'b1;
          state_q       <= StIdle;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
`ifdef NSA_FLAGS_EN
  assign zero        = zero_q;
  assign ovf         = ovf_q;
`else
  assign zero        = 1'b0;
  assign ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  typedef struct {
    longint unsigned sum;
    bit              cout;
    bit              zero;
    bit              ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         zero;
  logic         ovf;

  // Single-nibble build.
  logic       sv1, sr1, rv1, rr1, ci1, sb1, co1, z1, o1;
  logic [3:0] a1, b1, s1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .zero        (zero),
    .ovf         (ovf)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .start_valid (sv1),
    .start_ready (sr1),
    .op_a        (a1),
    .op_b        (b1),
    .cin         (ci1),
    .sub         (sb1),
    .res_valid   (rv1),
    .res_ready   (rr1),
    .sum         (s1),
    .cout        (co1),
    .zero        (z1),
    .ovf         (o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain modular/signed arithmetic on the full operands.
  function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                 input bit ci, input bit sb, input int w);
    exp_t            r;
    longint unsigned mask;
    longint unsigned u;
    longint          lim, sa, sbv, s;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sa   = (a >= longint'(lim)) ? longint'(a) - 2 * lim : longint'(a);
    sbv  = (b >= longint'(lim)) ? longint'(b) - 2 * lim : longint'(b);
    if (sb) begin
      r.sum  = (a - b) & mask;
      r.cout = (a >= b);
      s      = sa - sbv;
    end else begin
      u      = a + b + longint'(ci);
      r.sum  = u & mask;
      r.cout = ((u >> w) & 64'd1) != 64'd0;
      s      = sa + sbv + longint'(ci);
    end
    r.ovf  = (s >= lim) || (s < -lim);
    r.zero = (r.sum == 64'd0);
`ifndef NSA_FLAGS_EN
    r.zero = 1'b0;
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: compare whenever a result handshake is about to occur.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum %0h, expected no result", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum",  64'(sum),  e.sum);
        chk("cout", 64'(cout), 64'(e.cout));
        chk("zero", 64'(zero), 64'(e.zero));
        chk("ovf",  64'(ovf),  64'(e.ovf));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb, input int hold);
    exp_t e;
    bit   acc;
    e           = model(64'(a), 64'(b), ci, sb, W);
    res_ready   = (hold == 0);
    op_a        = a;
    op_b        = b;
    cin         = ci;
    sub         = sb;
    start_valid = 1'b1;
    acc         = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      if (start_ready) acc = 1'b1;
      @(posedge clk);
    end
    #1;
    start_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    exp_q.push_back(e);
    // Operand changes after the accept edge must not matter.
    op_a = W'($urandom);
    op_b = W'($urandom);
    cin  = 1'($urandom);
    sub  = 1'($urandom);
    for (int k = 1; k <= int'(N); k++) begin
      @(posedge clk);
      #1;
      chk("latency", 64'(res_valid), 64'(k == int'(N)));
    end
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      op_a        = W'($urandom);
      op_b        = W'($urandom);
      @(posedge clk);
      #1;
      chk("hold_sum",   64'(sum),         e.sum);
      chk("hold_cout",  64'(cout),        64'(e.cout));
      chk("hold_zero",  64'(zero),        64'(e.zero));
      chk("hold_ovf",   64'(ovf),         64'(e.ovf));
      chk("hold_ready", 64'(start_ready), 64'd0);
      chk("hold_valid", 64'(res_valid),   64'd1);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", 64'(start_ready), 64'd1);
    chk("idle_valid", 64'(res_valid),   64'd0);
  endtask

  initial begin
    exp_t e1;
    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op_a        = '0;
    op_b        = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    sv1         = 1'b0;
    rr1         = 1'b1;
    a1          = '0;
    b1          = '0;
    ci1         = 1'b0;
    sb1         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_res_valid",   64'(res_valid),   64'd0);
    chk("rst_sum",         64'(sum),         64'd0);
    chk("rst_cout",        64'(cout),        64'd0);
    chk("rst_zero",        64'(zero),        64'd0);
    chk("rst_ovf",         64'(ovf),         64'd0);

    // Single-nibble build: RUN lasts one cycle.
    a1  = 4'hF;
    b1  = 4'h1;
    ci1 = 1'b1;
    sv1 = 1'b1;
    e1  = model(64'hF, 64'h1, 1'b1, 1'b0, 4);
    @(negedge clk);
    chk("n1_ready", 64'(sr1), 64'd1);
    @(posedge clk);
    #1;
    sv1 = 1'b0;
    a1  = 4'h0;
    chk("n1_pre_valid", 64'(rv1), 64'd0);
    @(posedge clk);
    #1;
    chk("n1_valid", 64'(rv1), 64'd1);
    chk("n1_sum",   64'(s1),  e1.sum);
    chk("n1_cout",  64'(co1), 64'(e1.cout));
    chk("n1_ovf",   64'(o1),  64'(e1.ovf));
    @(posedge clk);
    #1;

    // Directed cases.
    run_op(W'(16'h1234), W'(16'h0FFF), 1'b0, 1'b0, 0);
    run_op(W'(16'hFFFF), W'(16'h0001), 1'b0, 1'b0, 1);
    run_op(W'(16'h8000), W'(16'h0001), 1'b1, 1'b1, 3);
    run_op(W'(16'h0001), W'(16'h0002), 1'b0, 1'b1, 0);
    run_op(W'(16'h7FFF), W'(16'h0000), 1'b1, 1'b0, 0);
    run_op(W'(16'h5A5A), W'(16'h5A5A), 1'b0, 1'b1, 2);

    // Reset in the middle of RUN, with idx at 2.
    res_ready   = 1'b1;
    op_a        = W'(16'h1111);
    op_b        = W'(16'h2222);
    cin         = 1'b0;
    sub         = 1'b0;
    start_valid = 1'b1;
    @(negedge clk);
    chk("mid_accept_ready", 64'(start_ready), 64'd1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", 64'(res_valid),   64'd0);
    chk("mid_rst_sum",   64'(sum),         64'd0);
    chk("mid_rst_ready", 64'(start_ready), 64'd1);
    repeat (N + 2) @(posedge clk);
    #1;
    run_op(W'(16'h0003), W'(16'h0004), 1'b0, 1'b0, 0);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i % 8 == 0) ? ra : W'($urandom);
      run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
